instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit.
- Holds the PC and issues one instruction-memory read at a time.
- Registers the returned 32-bit instruction and presents the decoded fields (opcode, funct3, funct7, register indices) to decode/control with a valid/ready handshake.
- Handles branch redirects from execute, including discarding an in-flight response.

Parameters:
- XLEN, 64, width of PC and addresses.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req_out  out  1  read request, one-cycle pulse
- imem_addr_out  out  XLEN  read address, valid while imem_req_out=1
- imem_rvalid_in  in  1  response valid, one cycle, ≥1 cycle after request
- imem_rdata_in  in  32  instruction word, valid with imem_rvalid_in
- id_valid_out  out  1  instruction fields valid
- id_ready_in  in  1  downstream accepts when id_valid_out & id_ready_in
- id_pc_out  out  XLEN  PC of presented instruction
- id_instr_out  out  32  raw instruction
- opcode_out  out  7  instr[6:0]
- funct3_out  out  3  instr[14:12]
- funct7_out  out  7  instr[31:25]
- rd_out  out  5  instr[11:7]
- rs1_out  out  5  instr[19:15]
- rs2_out  out  5  instr[24:20]
- redirect_in  in  1  taken branch; load redirect_pc_in
- redirect_pc_in  in  XLEN  branch target

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - pc=RESET_PC; state=FETCH.
  - imem_req_out=0, id_valid_out=0.
  - id_pc_out, id_instr_out and all field outputs = 0.
- Field outputs are pure slices of the registered id_instr_out; no extra latency.
- At most one outstanding imem request. No request is issued while in WAIT, DROP or HOLD.
- State machine:
  - FETCH: imem_req_out=1, imem_addr_out=pc.
    - redirect_in=1 in this cycle: the request is still issued and counts as outstanding; pc<=redirect_pc_in; ->DROP.
    - Otherwise ->WAIT.
  - WAIT:
    - rvalid & !redirect: id_instr<=rdata, id_pc<=pc, id_valid<=1, pc<=pc+4; ->HOLD.
    - redirect & !rvalid: pc<=redirect_pc_in; ->DROP.
    - redirect & rvalid in the same cycle: discard rdata; pc<=redirect_pc_in; ->FETCH.
  - DROP: on rvalid, discard rdata; ->FETCH. A redirect in DROP updates pc (last redirect wins) and stays in DROP.
  - HOLD: outputs stable while id_valid_out=1 & !id_ready_in.
    - redirect has priority over handshake: id_valid<=0, pc<=redirect_pc_in, ->FETCH. The held instruction is dropped even if id_ready_in=1.
    - Otherwise, if id_ready_in: id_valid<=0; ->FETCH.
- Latency/throughput:
  - Fetch-to-valid = imem latency + 1 cycle.
  - Minimum 3 cycles per instruction with 1-cycle memory.
- Arithmetic: pc+4 wraps modulo 2^XLEN (all-ones-3 -> 0), no flag.
- imem_rvalid_in while in FETCH or HOLD is a protocol violation: ignored, state unchanged.
- Reset mid-operation: immediate return to reset values. Any response arriving after reset deasserts while in FETCH is ignored per the rule above.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_fault_out (1 bit, reset 0) and state FAULT.
  - A redirect with redirect_pc_in[1:0]!=0 sets fetch_fault_out=1 (sticky until reset) and enters FAULT.
  - FAULT: no requests, id_valid_out=0; redirects and rvalid are ignored.
- Undefined:
  - No fault port or FAULT state.
  - redirect_pc_in[1:0] is forced to 2'b00 when loaded into pc.

Test Plan:
- Reset release, memory latency 1, id_ready_in=1, rdata=32'h00A50533 -> first req at addr 0; id_valid one cycle after rvalid; opcode=7'b0110011, rd=10, rs1=10, rs2=10, funct3=0, funct7=0; next req addr 4.
- Backpressure: id_ready_in=0 for 5 cycles in HOLD -> id_valid, id_pc, id_instr stable; no imem_req; release -> req at pc+4.
- Redirect to 0x100 while in WAIT; stale rvalid 2 cycles later with 32'hDEADBEEF -> response discarded, id_valid never asserts for it; next req addr 0x100.
- Redirect 0x200 coincident with rvalid in WAIT -> data discarded; next cycle req at 0x200. Redirect 0x300 in HOLD with id_ready_in=1 -> id_valid drops, no handshake counted, next req at 0x300.
- PC wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, fetch completes -> next req addr 0.
- Reset asserted while in WAIT -> outputs to reset values immediately; after release, req at RESET_PC. With FETCH_ALIGN_CHECK_EN: redirect to 0x102 -> fetch_fault_out=1, no further requests.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder issuing one imem read at a time, registering the instruction for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_fault_out and park in FAULT.
module instr_fetch_unit #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_out,
   output logic [XLEN-1:0] imem_addr_out,
   input  logic            imem_rvalid_in,
   input  logic [31:0]     imem_rdata_in,
   output logic            id_valid_out,
   input  logic            id_ready_in,
   output logic [XLEN-1:0] id_pc_out,
   output logic [31:0]     id_instr_out,
   output logic [6:0]      opcode_out,
   output logic [2:0]      funct3_out,
   output logic [6:0]      funct7_out,
   output logic [4:0]      rd_out,
   output logic [4:0]      rs1_out,
   output logic [4:0]      rs2_out,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic            fetch_fault_out,
`endif
   input  logic            redirect_in,
   input  logic [XLEN-1:0] redirect_pc_in
);
`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {FETCH, WAIT, DROP, HOLD, FAULT} state_t;
`else
   typedef enum logic [1:0] {FETCH, WAIT, DROP, HOLD} state_t;
`endif
   state_t            r_state, w_state;
   logic [XLEN-1:0]   r_pc, w_pc, r_id_pc, w_id_pc;
   logic [31:0]       r_instr, w_instr;
   logic              r_valid, w_valid;
   logic [XLEN-1:0]   w_target;
`ifdef FETCH_ALIGN_CHECK_EN
   assign w_target = redirect_pc_in;
`else
   assign w_target = redirect_pc_in & ~XLEN'(3);
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_id_pc <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state;
         r_pc    <= w_pc;
         r_id_pc <= w_id_pc;
         r_instr <= w_instr;
         r_valid <= w_valid;
      end
   end
   always_comb begin
      w_state = r_state;
      w_pc    = r_pc;
      w_id_pc = r_id_pc;
      w_instr = r_instr;
      w_valid = r_valid;
      case (r_state)
         FETCH: begin
            w_state = redirect_in ? DROP : WAIT;
            w_pc    = redirect_in ? w_target : r_pc;
         end
         WAIT: begin
            if (redirect_in) begin
               w_pc    = w_target;
               w_state = imem_rvalid_in ? FETCH : DROP;
            end else if (imem_rvalid_in) begin
               w_instr = imem_rdata_in;
               w_id_pc = r_pc;
               w_valid = 1'b1;
               w_pc    = r_pc + XLEN'(4);
               w_state = HOLD;
            end
         end
         DROP: begin
            w_pc    = redirect_in ? w_target : r_pc;
            w_state = imem_rvalid_in ? FETCH : DROP;
         end
         HOLD: begin
            // a redirect kills the held instruction even if it is being accepted
            w_pc    = redirect_in ? w_target : r_pc;
            w_valid = r_valid & ~redirect_in & ~id_ready_in;
            w_state = (redirect_in | id_ready_in) ? FETCH : HOLD;
         end
         default: ;
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      if (r_state != FAULT && redirect_in && redirect_pc_in[1:0] != 2'b00) begin
         w_state = FAULT;
         w_pc    = r_pc;
         w_valid = 1'b0;
      end
`endif
   end
   assign imem_req_out  = (r_state == FETCH) & ~reset;
   assign imem_addr_out = r_pc;
   assign id_valid_out  = r_valid;
   assign id_pc_out     = r_id_pc;
   assign id_instr_out  = r_instr;
   assign opcode_out    = r_instr[6:0];
   assign rd_out        = r_instr[11:7];
   assign funct3_out    = r_instr[14:12];
   assign rs1_out       = r_instr[19:15];
   assign rs2_out       = r_instr[24:20];
   assign funct7_out    = r_instr[31:25];
`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_fault_out = (r_state == FAULT);
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of instr_fetch_unit against a transaction-level model.
module tb_instr_fetch_unit;
   logic        clk = 1'b0, reset = 1'b1;
   logic        imem_req_out, imem_rvalid_in = 1'b0, id_valid_out, id_ready_in = 1'b0, redirect_in = 1'b0;
   logic [63:0] imem_addr_out, id_pc_out, redirect_pc_in = '0;
   logic [31:0] imem_rdata_in = '0, id_instr_out;
   logic [6:0]  opcode_out, funct7_out;
   logic [2:0]  funct3_out;
   logic [4:0]  rd_out, rs1_out, rs2_out;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_fault_out;
`endif
   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
      .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
      .id_valid_out(id_valid_out), .id_ready_in(id_ready_in),
      .id_pc_out(id_pc_out), .id_instr_out(id_instr_out),
      .opcode_out(opcode_out), .funct3_out(funct3_out), .funct7_out(funct7_out),
      .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
`ifdef FETCH_ALIGN_CHECK_EN
      .fetch_fault_out(fetch_fault_out),
`endif
      .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in)
   );

   int total = 0, bad = 0;
   // model: outstanding request, response to be discarded, held instruction
   logic [63:0] m_pc, m_id_pc;
   logic [31:0] m_instr, fdata;
   bit          m_out, m_stale, m_valid, mem_busy, use_f;
   int          mem_left, lat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] tgt(input logic [63:0] p);
      return {p[63:2], 2'b00};
   endfunction

   task automatic model_reset();
      m_pc = '0; m_id_pc = '0; m_instr = '0;
      m_out = 0; m_stale = 0; m_valid = 0; mem_busy = 0; mem_left = 0;
      imem_rvalid_in = 0; redirect_in = 0; id_ready_in = 0;
   endtask

   task automatic check_all();
      bit er;
      er = !m_out && !m_valid;
      chk("req", 64'(imem_req_out), 64'(er));
      if (er) chk("addr", imem_addr_out, m_pc);
      chk("valid", 64'(id_valid_out), 64'(m_valid));
      chk("id_pc", id_pc_out, m_id_pc);
      chk("instr", 64'(id_instr_out), 64'(m_instr));
      chk("opcode", 64'(opcode_out), 64'(m_instr[6:0]));
      chk("rd", 64'(rd_out), 64'(m_instr[11:7]));
      chk("funct3", 64'(funct3_out), 64'(m_instr[14:12]));
      chk("rs1", 64'(rs1_out), 64'(m_instr[19:15]));
      chk("rs2", 64'(rs2_out), 64'(m_instr[24:20]));
      chk("funct7", 64'(funct7_out), 64'(m_instr[31:25]));
   endtask

   task automatic step(input bit rdy, input bit rd, input logic [63:0] rpc);
      bit          er, rv;
      logic [31:0] d;
      er = !m_out && !m_valid;
      rv = mem_busy && mem_left == 0;
      d  = use_f ? fdata : $urandom;
      imem_rvalid_in = rv; imem_rdata_in = rv ? d : 32'h0;
      id_ready_in = rdy; redirect_in = rd; redirect_pc_in = rpc;
      if (er) begin
         m_out = 1; m_stale = rd;
         if (rd) m_pc = tgt(rpc);
      end else if (m_out) begin
         if (rv && !m_stale && !rd) begin
            m_instr = d; m_id_pc = m_pc; m_valid = 1; m_pc = m_pc + 64'd4;
         end
         if (rd) begin m_pc = tgt(rpc); m_stale = 1; end
         if (rv) begin m_out = 0; m_stale = 0; end
      end else if (m_valid) begin
         if (rd) begin m_valid = 0; m_pc = tgt(rpc); end
         else if (rdy) m_valid = 0;
      end
      if (rv) mem_busy = 0;
      else if (mem_busy) mem_left--;
      if (er) begin mem_busy = 1; mem_left = lat - 1; end
      @(posedge clk);
      @(negedge clk);
      imem_rvalid_in = 0; redirect_in = 0;
      check_all();
   endtask

   initial begin
      model_reset();
      lat = 1; use_f = 1; fdata = 32'h00A50533;
      repeat (2) @(negedge clk);
      chk("rst_req", 64'(imem_req_out), 64'd0);
      chk("rst_valid", 64'(id_valid_out), 64'd0);
      chk("rst_id_pc", id_pc_out, 64'd0);
      chk("rst_instr", 64'(id_instr_out), 64'd0);
      chk("rst_opcode", 64'(opcode_out), 64'd0);
      reset = 0;
      #1 check_all();
      chk("t1_req", 64'(imem_req_out), 64'd1);
      chk("t1_addr", imem_addr_out, 64'd0);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("t1_valid", 64'(id_valid_out), 64'd1);
      chk("t1_opcode", 64'(opcode_out), 64'b0110011);
      chk("t1_rd", 64'(rd_out), 64'd10);
      chk("t1_rs1", 64'(rs1_out), 64'd10);
      chk("t1_rs2", 64'(rs2_out), 64'd10);
      chk("t1_funct3", 64'(funct3_out), 64'd0);
      chk("t1_funct7", 64'(funct7_out), 64'd0);
      step(1, 0, 0);
      chk("t1_next_addr", imem_addr_out, 64'd4);
      // backpressure
      step(0, 0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0);
         chk("bp_valid", 64'(id_valid_out), 64'd1);
         chk("bp_id_pc", id_pc_out, 64'd4);
         chk("bp_noreq", 64'(imem_req_out), 64'd0);
      end
      step(1, 0, 0);
      chk("bp_next_addr", imem_addr_out, 64'd8);
      // redirect in WAIT, stale response later
      lat = 3; fdata = 32'hDEADBEEF;
      step(1, 0, 0);
      step(1, 1, 64'h100);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("stale_valid", 64'(id_valid_out), 64'd0);
      chk("stale_addr", imem_addr_out, 64'h100);
      // redirect coincident with rvalid, then redirect in HOLD
      lat = 1; fdata = 32'h00A50533;
      step(1, 0, 0);
      step(1, 1, 64'h200);
      chk("coin_addr", imem_addr_out, 64'h200);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 64'h300);
      chk("hold_redir_valid", 64'(id_valid_out), 64'd0);
      chk("hold_redir_addr", imem_addr_out, 64'h300);
      // pc wrap
      step(1, 0, 0);
      step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("wrap_id_pc", id_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1, 0, 0);
      chk("wrap_addr", imem_addr_out, 64'd0);
      // reset in WAIT
      step(1, 0, 0);
      #2 reset = 1;
      #1;
      chk("mid_rst_req", 64'(imem_req_out), 64'd0);
      chk("mid_rst_valid", 64'(id_valid_out), 64'd0);
      chk("mid_rst_id_pc", id_pc_out, 64'd0);
      chk("mid_rst_instr", 64'(id_instr_out), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 0;
      #1 check_all();
      chk("post_rst_addr", imem_addr_out, 64'd0);
      // random traffic
      use_f = 0;
      for (int i = 0; i < 600; i++) begin
         logic [63:0] rpc;
         lat = $urandom_range(1, 3);
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rpc[63:32] = 32'hFFFF_FFFF;
`ifdef FETCH_ALIGN_CHECK_EN
         rpc[1:0] = 2'b00;
`endif
         step($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, rpc);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      reset = 1;
      @(negedge clk);
      reset = 0;
      redirect_in = 1; redirect_pc_in = 64'h102;
      @(posedge clk);
      @(negedge clk);
      redirect_in = 0;
      chk("fault_set", 64'(fetch_fault_out), 64'd1);
      for (int i = 0; i < 4; i++) begin
         imem_rvalid_in = $urandom_range(0, 1); redirect_in = $urandom_range(0, 1);
         redirect_pc_in = 64'h400; id_ready_in = 1;
         @(posedge clk);
         @(negedge clk);
         chk("fault_noreq", 64'(imem_req_out), 64'd0);
         chk("fault_novalid", 64'(id_valid_out), 64'd0);
         chk("fault_sticky", 64'(fetch_fault_out), 64'd1);
      end
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
